// File: rtl/input_conditioner.sv
// Pushbutton/switch input conditioner: synchronise, debounce, one-shot enter pulse, word capture with valid/ack.
// Optional build macro INCOND_AUTOREPEAT_EN adds periodic re-capture while the button is held.
module input_conditioner #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 1000000
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              nenter_raw,
    input  logic [DATA_W-1:0] data_raw,
    output logic              enter_pulse,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              overrun,
    output logic              pressed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2)     begin : g_bad_sync   $error("SYNC_STAGES must be >= 2");     end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_db     $error("DEBOUNCE_CYCLES must be >= 2"); end
    if (REPEAT_CYCLES < 2)   begin : g_bad_repeat $error("REPEAT_CYCLES must be >= 2");   end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0]             nsync_q, nsync_d;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] dsync_q, dsync_d;
    logic                               s_n;
    logic [DATA_W-1:0]                  s_data;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fire;
    logic              enter_pulse_d, data_valid_d, overrun_d, pressed_d;
    logic [DATA_W-1:0] data_out_d;

`ifdef INCOND_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    // Shift registers toward the last (stable) stage
    always_comb begin
        nsync_d = {nsync_q[SYNC_STAGES-2:0], nenter_raw};
        dsync_d = {dsync_q[SYNC_STAGES-2:0], data_raw};
    end

    assign s_n    = nsync_q[SYNC_STAGES-1];
    assign s_data = dsync_q[SYNC_STAGES-1];

    // Debounce FSM; fire marks an accepted press (or a repeat)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
`ifdef INCOND_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!s_n) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (s_n) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = PRESSED;
                    fire    = 1'b1;
`ifdef INCOND_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (s_n) begin
                    state_d = DB_RELEASE;
                    cnt_d   = '0;
                end
`ifdef INCOND_AUTOREPEAT_EN
                else if (rpt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
                    fire  = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
`endif
            end
            DB_RELEASE: begin
                if (!s_n) begin
                    state_d = PRESSED;
`ifdef INCOND_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture and handshake; a same-edge ack frees the slot for the new word
    always_comb begin
        enter_pulse_d = fire;
        data_out_d    = data_out;
        data_valid_d  = data_valid;
        overrun_d     = overrun;
        pressed_d     = (state_d == PRESSED) || (state_d == DB_RELEASE);
        if (data_valid && data_ack) begin
            data_valid_d = 1'b0;
        end
        if (fire) begin
            if (!data_valid || data_ack) begin
                data_out_d   = s_data;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nsync_q     <= '1;
            dsync_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            enter_pulse <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            pressed     <= 1'b0;
        end else begin
            nsync_q     <= nsync_d;
            dsync_q     <= dsync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enter_pulse <= enter_pulse_d;
            data_out    <= data_out_d;
            data_valid  <= data_valid_d;
            overrun     <= overrun_d;
            pressed     <= pressed_d;
        end
    end

`ifdef INCOND_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected capture results queued per press, checked on each enter_pulse.
module tb_input_conditioner;

    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned RC = 20;

    logic          clk;
    logic          nreset;
    logic          nenter_raw;
    logic [DW-1:0] data_raw;
    logic          enter_pulse;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ack;
    logic          overrun;
    logic          pressed;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic          ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;

    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovr;

    input_conditioner #(
        .DATA_W         (DW),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .nenter_raw (nenter_raw),
        .data_raw   (data_raw),
        .enter_pulse(enter_pulse),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .overrun    (overrun),
        .pressed    (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one capture event, queued for the monitor
    task automatic push_expect(input logic [DW-1:0] d, input logic ack);
        exp_t e;
        if (!m_valid || ack) begin
            m_data  = d;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        e.data  = m_data;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [DW-1:0] d, input logic ack_at_pulse);
        data_raw   = d;
        nenter_raw = 1'b0;
        push_expect(d, ack_at_pulse);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            data_ack = ack_at_pulse && (k == 5);
        end
        nenter_raw = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_ack();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        m_valid  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (nreset && enter_pulse) begin
            exp_t e;
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pulse", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_data_out", 32'(data_out), 32'(e.data));
                check("sb_data_valid", 32'(data_valid), 32'(e.valid));
                check("sb_overrun", 32'(overrun), 32'(e.ovr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int extra;
        nreset     = 1'b0;
        nenter_raw = 1'b1;
        data_raw   = '0;
        data_ack   = 1'b0;
        m_data     = '0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pulse", 32'(enter_pulse), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_ovr", 32'(overrun), 32'(0));
        check("rst_pressed", 32'(pressed), 32'(0));
        nreset = 1'b1;
        @(negedge clk);

        // First-press latency: pulse visible only after edge SS+DB
        data_raw   = 8'hA5;
        nenter_raw = 1'b0;
        push_expect(8'hA5, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("lat_pulse", 32'(enter_pulse), 32'(k == 6));
        end
        check("lat_data", 32'(data_out), 32'(8'hA5));
        check("lat_valid", 32'(data_valid), 32'(1));
        check("lat_pressed", 32'(pressed), 32'(1));
        nenter_raw = 1'b1;
        repeat (8) @(negedge clk);
        check("lat_released", 32'(pressed), 32'(0));
        do_ack();
        check("ack_clears_valid", 32'(data_valid), 32'(0));

        // Press bounce: never stable long enough
        base = pulse_cnt;
        data_raw = 8'hEE;
        nenter_raw = 1'b0; @(negedge clk); @(negedge clk);
        nenter_raw = 1'b1; @(negedge clk);
        nenter_raw = 1'b0; @(negedge clk); @(negedge clk);
        nenter_raw = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_no_pulse", 32'(pulse_cnt), 32'(base));
        check("bounce_valid", 32'(data_valid), 32'(0));
        check("bounce_pressed", 32'(pressed), 32'(0));

        // Release bounce: one pulse, pressed held through toggles
        base = pulse_cnt;
        data_raw   = 8'h11;
        nenter_raw = 1'b0;
        push_expect(8'h11, 1'b0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            nenter_raw = 1'b1; @(negedge clk);
            nenter_raw = 1'b0; @(negedge clk);
            check("relb_pressed_hold", 32'(pressed), 32'(1));
        end
        nenter_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("relb_pressed", 32'(pressed), 32'(k < 6));
        end
        check("relb_one_pulse", 32'(pulse_cnt), 32'(base + 1));
        do_ack();

        // Handshake and overrun
        press(8'h3C, 1'b0);
        check("hs_data1", 32'(data_out), 32'(8'h3C));
        check("hs_ovr0", 32'(overrun), 32'(0));
        press(8'hC3, 1'b0);
        check("hs_data_held", 32'(data_out), 32'(8'h3C));
        check("hs_ovr1", 32'(overrun), 32'(1));
        check("hs_valid", 32'(data_valid), 32'(1));
        do_ack();
        check("hs_ack", 32'(data_valid), 32'(0));
        press(8'h0F, 1'b0);
        check("hs_data2", 32'(data_out), 32'(8'h0F));
        check("hs_valid2", 32'(data_valid), 32'(1));

        // Ack and capture on the same edge
        press(8'h55, 1'b1);
        check("sim_data", 32'(data_out), 32'(8'h55));
        check("sim_valid", 32'(data_valid), 32'(1));
        check("sim_ovr", 32'(overrun), 32'(1));

        // Asynchronous reset mid-debounce, then held button re-qualifies
        base = pulse_cnt;
        data_raw   = 8'h99;
        nenter_raw = 1'b0;
        repeat (4) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("arst_pulse", 32'(enter_pulse), 32'(0));
        check("arst_data", 32'(data_out), 32'(0));
        check("arst_valid", 32'(data_valid), 32'(0));
        check("arst_ovr", 32'(overrun), 32'(0));
        check("arst_pressed", 32'(pressed), 32'(0));
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        @(negedge clk);
        check("arst_no_pulse", 32'(pulse_cnt), 32'(base));
        nreset = 1'b1;
        push_expect(8'h99, 1'b0);
        repeat (10) @(negedge clk);
        check("arst_one_pulse", 32'(pulse_cnt), 32'(base + 1));
        nenter_raw = 1'b1;
        repeat (8) @(negedge clk);

        // Long hold: repeats only when the auto-repeat build is selected
        do_ack();
        base = pulse_cnt;
        data_raw   = 8'h77;
        nenter_raw = 1'b0;
        push_expect(8'h77, 1'b0);
`ifdef INCOND_AUTOREPEAT_EN
        push_expect(8'h77, 1'b0);
        push_expect(8'h77, 1'b0);
        extra = 2;
`else
        extra = 0;
`endif
        repeat (56) @(negedge clk);
        nenter_raw = 1'b1;
        repeat (8) @(negedge clk);
        check("hold_pulses", 32'(pulse_cnt), 32'(base + 1 + extra));
        check("hold_data", 32'(data_out), 32'(8'h77));

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Upstream conditioning stage between the board pushbutton/switches and the top-level control/datapath pair. It synchronises the active-low enter button and the 8-bit switch bus, debounces the button with a press/release FSM, and emits a single-cycle enter pulse. On that pulse it also captures the switch word into a holding register. A valid/ack handshake presents the captured word to the datapath.

Parameters:
DATA_W, 8, width of switch bus and captured word
SYNC_STAGES, 2, synchroniser flops per input bit (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a level change (>=2)
REPEAT_CYCLES, 1000000, held-button cycles between auto-repeat pulses (used only with INCOND_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
nreset  in  1  asynchronous active-low reset
nenter_raw  in  1  raw pushbutton, low = pressed, bouncy, asynchronous
data_raw  in  DATA_W  raw switch bus, asynchronous
enter_pulse  out  1  one-cycle high pulse per accepted press
data_out  out  DATA_W  captured switch word
data_valid  out  1  data_out holds an unconsumed word
data_ack  in  1  consumer accepts data_out
overrun  out  1  sticky: a press completed while data_valid=1 and no ack
pressed  out  1  debounced button level, 1 = held

Behaviour:
- One clock; reset is asynchronous and active-low (clk, nreset); all state clears immediately on nreset=0, independent of clk.
- Reset values: enter_pulse=0, data_out=0, data_valid=0, overrun=0, pressed=0, FSM=IDLE, counters=0. nenter synchroniser flops reset to 1 (released); data synchroniser flops reset to 0.
- Sync: nenter_raw and each data_raw bit pass through SYNC_STAGES flops. s_n and s_data denote the last-stage outputs.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES).
- FSM states and transitions:
  IDLE: s_n=0 -> DB_PRESS with cnt=0.
  DB_PRESS: s_n=1 -> IDLE (bounce, no pulse). s_n=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise cnt+1.
  PRESSED: s_n=1 -> DB_RELEASE with cnt=0.
  DB_RELEASE: s_n=0 -> PRESSED (bounce, no second pulse). s_n=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt+1.
- pressed=1 in PRESSED and DB_RELEASE.
- Transition DB_PRESS->PRESSED, at the same edge:
  - enter_pulse set to 1 for exactly one cycle.
  - data_out<=s_data if data_valid=0 or data_ack=1; data_valid<=1.
  - If data_valid=1 and data_ack=0: data_out is held and overrun is set.
- Latency: with nenter_raw first sampled low at edge 0 and held low, enter_pulse is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Handshake: data_ack=1 while data_valid=1 clears data_valid at the next edge. If an ack and a capture share an edge, the new word loads and data_valid stays 1. data_ack while data_valid=0 is ignored.
- overrun clears only on reset.
- Reset released while the button is held: s_n starts at 1, then falls; this is a normal press and produces one pulse.
- Reset asserted mid-debounce or mid-press: state is lost and no pulse is emitted. After release the block re-qualifies from IDLE.

Optional Feature:
INCOND_AUTOREPEAT_EN
- Defined: a repeat counter runs while in PRESSED, reset to 0 on entry to PRESSED. On reaching REPEAT_CYCLES-1 it emits another enter_pulse, performs a capture with the same rules as above (including overrun), and restarts at 0. The counter freezes in DB_RELEASE and resets on return to PRESSED.
- Undefined: exactly one pulse per debounced press; REPEAT_CYCLES is unused and no repeat counter is synthesised.

Test Plan:
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4: reset, data_raw=8'hA5, nenter_raw low at edge 0 and held -> enter_pulse high only after edge 6, data_out=8'hA5, data_valid=1, pressed=1.
- Bounce on press: nenter_raw low 2 cycles, high 1, low 2, then high -> no enter_pulse, data_valid stays 0, FSM back in IDLE.
- Release bounce: after an accepted press, nenter_raw toggles high/low 3 times, then steady high -> one pulse total; pressed drops after 4 stable high samples.
- Handshake: press with 8'h3C, no ack, press with 8'hC3 -> data_out=8'h3C, overrun=1. Ack, then press with 8'h0F -> data_out=8'h0F, data_valid=1.
- Simultaneous ack and capture: data_ack=1 on the pulse edge with 8'h55 -> data_out=8'h55, data_valid remains 1, overrun unchanged.
- nreset pulled low mid-DB_PRESS (asynchronous, between edges) -> all outputs 0 immediately. Held button after release -> exactly one pulse. With INCOND_AUTOREPEAT_EN and REPEAT_CYCLES=20, holding 50 cycles after acceptance -> 2 extra pulses.
